serial_tx_controller: RTL and testbench

Sequencing controller for the serial transmitter. It waits for the sequence detector's match pulse `W` on serial line `J`, then captures a `CNT_W`-bit length field from `J`, MSB first. It then forwards exactly that many payload bits from `J` to a registered serial output with a valid strobe, and pulses `Done`. It sits directly downstream of `SequenceDetector`, sharing `Clk`, `Rst` and `J` with it.

---
 rtl/serial_tx_controller.sv | 123 ++++++++++++
 tb/tb_serial_tx_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx_controller.sv
// serial_tx_controller: after a detector match on W, shifts a CNT_W-bit
// length off J (MSB first), then forwards that many payload bits to SerOut.
// Optional feature macro: SERIAL_TX_PARITY_EN adds an even-parity cycle
// after the payload, before Done.
// Ports:
//   Clk, Rst (async, active-low)  clock and reset
//   J, W                          serial line and detector match pulse
//   SerOut, SerValid              registered payload/parity bit and strobe
//   Busy, Done                    state != IDLE, one-cycle end-of-frame
//   CntOut                        payload bits remaining
module serial_tx_controller #(
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             J,
    input  logic             W,
    output logic             SerOut,
    output logic             SerValid,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CntOut
);

    localparam int IW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CNT,
        S_TRANSMIT,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_DONE
    } state_t;

`ifdef SERIAL_TX_PARITY_EN
    localparam state_t TAIL = S_PARITY;
`else
    localparam state_t TAIL = S_DONE;
`endif

    state_t           state;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] len_nxt;
`ifdef SERIAL_TX_PARITY_EN
    logic             par;
`endif

    // Shift in the next length bit; the old MSB falls off.
    assign len_nxt = CNT_W'({len, J});

    assign Busy = (state != S_IDLE);
    assign Done = (state == S_DONE);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            len      <= '0;
            SerOut   <= 1'b0;
            SerValid <= 1'b0;
            CntOut   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    SerValid <= 1'b0;
                    if (W) begin
                        state <= S_GET_CNT;
                        idx   <= '0;
                        len   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        par   <= 1'b0;
`endif
                    end
                end
                S_GET_CNT: begin
                    len <= len_nxt;
                    idx <= idx + 1'b1;
                    if (idx == IW'(CNT_W - 1)) begin
                        CntOut <= len_nxt;
                        // A zero length never enters TRANSMIT, so the
                        // down-counter cannot wrap.
                        if (len_nxt != '0)
                            state <= S_TRANSMIT;
                        else
                            state <= TAIL;
                    end
                end
                S_TRANSMIT: begin
                    SerOut   <= J;
                    SerValid <= 1'b1;
                    CntOut   <= CntOut - 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    par      <= par ^ J;
`endif
                    if (CntOut == CNT_W'(1))
                        state <= TAIL;
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    SerOut   <= par;
                    SerValid <= 1'b0;
                    state    <= S_DONE;
                end
`endif
                S_DONE: begin
                    SerValid <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    SerValid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_controller.sv
// tb_serial_tx_controller: random and directed frames checked cycle by
// cycle against a frame-level timing model of serial_tx_controller.
module tb_serial_tx_controller;

    localparam int CW = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          j;
    logic          w;
    logic          so;
    logic          sv;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    int   total = 0;
    int   bad   = 0;
    logic exp_so;

    serial_tx_controller #(.CNT_W(CW)) dut (
        .Clk     (clk),
        .Rst     (rst),
        .J       (j),
        .W       (w),
        .SerOut  (so),
        .SerValid(sv),
        .Busy    (busy),
        .Done    (done),
        .CntOut  (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".so"}, so, 0);
        chk({tag, ".sv"}, sv, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".cnt"}, cnt, 0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            w = 1'b0;
            j = 1'($urandom);
            @(negedge clk);
            chk("idle.busy", busy, 0);
            chk("idle.done", done, 0);
            chk("idle.so", so, exp_so);
        end
    endtask

    // Called at a negedge: drives W for edge 0, then checks the outputs
    // seen after every edge c of the frame. Done sits after edge d, where
    // d = CW + n (+1 with parity); IDLE is back after edge d+1.
    task automatic frame(input int n, input logic [14:0] pay,
                         input bit noise, input int abort_at);
        int            d;
        logic          pb;
        logic [CW-1:0] lv;
        logic          e_busy;
        logic          e_done;
        logic          e_valid;
        int            e_cnt;
        d  = CW + n + P;
        pb = 1'b0;
        for (int i = 0; i < n; i++) pb ^= pay[i];
        lv = CW'(n);
        w  = 1'b1;
        j  = 1'($urandom);
        for (int c = 0; c <= d + 1; c++) begin
            @(negedge clk);
            e_busy  = (c <= d);
            e_done  = (c == d);
            e_valid = (c >= CW + 1) && (c <= CW + n);
            if (c < CW)
                e_cnt = 0;
            else if (c <= CW + n)
                e_cnt = n - (c - CW);
            else
                e_cnt = 0;
            if (e_valid)
                exp_so = pay[c - CW - 1];
            else if (P == 1 && c == d)
                exp_so = pb;
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("valid", sv, e_valid);
            chk("cnt", cnt, e_cnt);
            chk("serout", so, exp_so);
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                chk_zero("abort");
                exp_so = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    w = 1'($urandom);
                    @(negedge clk);
                    chk("rst.busy", busy, 0);
                    chk("rst.done", done, 0);
                end
                w   = 1'b0;
                rst = 1'b1;
                return;
            end
            w = (noise && c <= d) ? 1'($urandom) : 1'b0;
            if (c < CW)
                j = lv[CW - 1 - c];
            else if (c < CW + n)
                j = pay[c - CW];
            else
                j = 1'($urandom);
        end
    endtask

    initial begin
        rst    = 1'b0;
        w      = 1'b0;
        j      = 1'b0;
        exp_so = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        idle(3);
        // basic: length 3, payload 1,0,1
        frame(3, 15'b101, 1'b0, -1);
        idle(2);
        // zero length
        frame(0, 15'h0, 1'b0, -1);
        idle(1);
        // max length, all ones
        frame(15, 15'h7fff, 1'b0, -1);
        idle(1);
        // stray W pulses while busy
        frame(2, 15'b01, 1'b1, -1);
        idle(2);
        // reset during the second payload bit
        frame(5, 15'b10110, 1'b0, CW + 2);
        idle(2);
        frame(4, 15'b1001, 1'b0, -1);
        // back-to-back
        frame(3, 15'b110, 1'b0, -1);
        frame(6, 15'b101101, 1'b0, -1);
        idle(1);
        for (int f = 0; f < 30; f++) begin
            frame($urandom_range(0, 15), 15'($urandom),
                  1'($urandom), -1);
            idle($urandom_range(0, 2));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
